// File: rtl/axi_llc_write_unit_pkg.sv
// Shared types, LLC geometry and AXI helpers for the LLC write unit.
// Geometry: 64-bit data words, 8 words per line, 64 sets.
package axi_llc_write_unit_pkg;

  localparam int unsigned ByteOffsetLength  = 3;
  localparam int unsigned BlockOffsetLength = 3;
  localparam int unsigned IndexLength       = 6;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 64;
  localparam int unsigned StrbW   = DataW / 8;
  localparam int unsigned IdW     = 4;
  localparam int unsigned LenW    = 8;
  localparam int unsigned WayIndW = 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {RChanUnit, WChanUnit, EvictUnit, RefilUnit} cache_unit_e;

  typedef enum logic [1:0] {IDLE, WRITE, UNLOCK} wu_state_e;

  typedef struct packed {
    logic [IdW-1:0]         a_x_id;
    logic [AddrW-1:0]       a_x_addr;
    logic [LenW-1:0]        a_x_len;
    logic [2:0]             a_x_size;
    logic [1:0]             a_x_burst;
    logic [1:0]             x_resp;
    logic                   x_last;
    logic [WayIndW-1:0]     way_ind;
    logic [IndexLength-1:0] index_partition;
  } desc_t;

  typedef struct packed {
    cache_unit_e                  cache_unit;
    logic                         we;
    logic [WayIndW-1:0]           way_ind;
    logic [IndexLength-1:0]       line_addr;
    logic [BlockOffsetLength-1:0] blk_offset;
    logic [DataW-1:0]             data;
    logic [StrbW-1:0]             be;
  } way_inp_t;

  typedef struct packed {
    logic [IndexLength-1:0] index;
    logic [WayIndW-1:0]     way_ind;
  } lock_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  function automatic logic [AddrW-1:0] num_bytes(input logic [2:0] size);
    return AddrW'(1) << size;
  endfunction

  function automatic logic [AddrW-1:0] aligned_addr(input logic [AddrW-1:0] addr,
                                                    input logic [2:0]       size);
    return addr & ~(num_bytes(size) - AddrW'(1));
  endfunction

endpackage

// File: rtl/axi_llc_write_unit_bfifo.sv
// B response queue: registered output (no fall-through), push ignored when full,
// pop ignored when empty.
module axi_llc_write_unit_bfifo
  import axi_llc_write_unit_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  b_chan_t data_i,
  input  logic    pop_i,
  output b_chan_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  b_chan_t         mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi_llc_write_unit.sv
// LLC write unit: streams W beats of one descriptor into byte-masked data-way
// writes, then releases the line lock and, on burst close, queues the B response.
module axi_llc_write_unit
  import axi_llc_write_unit_pkg::*;
#(
  parameter bit          CachePartition = 1'b1,
  parameter int unsigned BFifoDepth     = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  desc_t    desc_i,
  input  logic     desc_valid_i,
  output logic     desc_ready_o,
  input  w_chan_t  w_chan_slv_i,
  input  logic     w_chan_valid_i,
  output logic     w_chan_ready_o,
  output b_chan_t  b_chan_slv_o,
  output logic     b_chan_valid_o,
  input  logic     b_chan_ready_i,
  output way_inp_t way_inp_o,
  output logic     way_inp_valid_o,
  input  logic     way_inp_ready_i,
  output lock_t    w_unlock_o,
  output logic     w_unlock_req_o,
  input  logic     w_unlock_gnt_i
);

  wu_state_e              state_q, state_d;
  desc_t                  desc_q, desc_d;
  logic [IndexLength-1:0] line_addr;
  logic                   b_push, b_full, b_empty;
  b_chan_t                b_push_data;

  assign line_addr = CachePartition ? desc_q.index_partition
                   : desc_q.a_x_addr[ByteOffsetLength + BlockOffsetLength +: IndexLength];

  always_comb begin
    state_d         = state_q;
    desc_d          = desc_q;
    desc_ready_o    = 1'b0;
    w_chan_ready_o  = 1'b0;
    way_inp_valid_o = 1'b0;
    w_unlock_req_o  = 1'b0;
    b_push          = 1'b0;
    b_push_data     = '{id: desc_q.a_x_id, resp: desc_q.x_resp};
    w_unlock_o      = '{index: line_addr, way_ind: desc_q.way_ind};
    // Error beats are consumed with an empty byte mask so nothing lands in the way.
    way_inp_o       = '{cache_unit: WChanUnit,
                        we:         1'b1,
                        way_ind:    desc_q.way_ind,
                        line_addr:  line_addr,
                        blk_offset: desc_q.a_x_addr[ByteOffsetLength +: BlockOffsetLength],
                        data:       w_chan_slv_i.data,
                        be:         (desc_q.x_resp == RESP_OKAY) ? w_chan_slv_i.strb : '0};
    case (state_q)
      IDLE: begin
        desc_ready_o = 1'b1;
        if (desc_valid_i) begin
          desc_d  = desc_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        way_inp_valid_o = w_chan_valid_i;
        w_chan_ready_o  = way_inp_ready_i;
        if (w_chan_valid_i && way_inp_ready_i) begin
          if (desc_q.a_x_len != '0) begin
            desc_d.a_x_len = desc_q.a_x_len - LenW'(1);
            if (desc_q.a_x_burst != BURST_FIXED) begin
              desc_d.a_x_addr = aligned_addr(desc_q.a_x_addr + num_bytes(desc_q.a_x_size),
                                             desc_q.a_x_size);
            end
          end else begin
            state_d = UNLOCK;
          end
        end
      end
      UNLOCK: begin
        w_unlock_req_o = 1'b1;
        // Hold the unlock until the B slot is guaranteed, so grant and push stay paired.
        if (w_unlock_gnt_i && (!desc_q.x_last || !b_full)) begin
          b_push  = desc_q.x_last;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
    end
  end

  axi_llc_write_unit_bfifo #(
    .Depth (BFifoDepth)
  ) i_b_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (b_push),
    .data_i  (b_push_data),
    .pop_i   (b_chan_ready_i & ~b_empty),
    .data_o  (b_chan_slv_o),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  assign b_chan_valid_o = ~b_empty;

  // The beat count in the descriptor sequences the unit; w.last must agree with it.
  a_w_last_consistent : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == WRITE && w_chan_valid_i && w_chan_ready_o) |->
    (w_chan_slv_i.last == (desc_q.x_last && desc_q.a_x_len == '0)));

endmodule

// File: tb/tb_axi_llc_write_unit.sv
// Randomized bench for axi_llc_write_unit with a transaction-level scoreboard.
module tb_axi_llc_write_unit;
  import axi_llc_write_unit_pkg::*;

  localparam int Depth = 2;

  logic     clk = 1'b0;
  logic     rst_ni = 1'b0;
  desc_t    desc_i = '0;
  logic     desc_valid_i = 1'b0;
  logic     desc_ready_o;
  w_chan_t  w_chan_slv_i = '0;
  logic     w_chan_valid_i = 1'b0;
  logic     w_chan_ready_o;
  b_chan_t  b_chan_slv_o;
  logic     b_chan_valid_o;
  logic     b_chan_ready_i = 1'b0;
  way_inp_t way_inp_o;
  logic     way_inp_valid_o;
  logic     way_inp_ready_i = 1'b0;
  lock_t    w_unlock_o;
  logic     w_unlock_req_o;
  logic     w_unlock_gnt_i = 1'b0;

  always #5 clk = ~clk;

  axi_llc_write_unit #(
    .CachePartition (1'b1),
    .BFifoDepth     (Depth)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .desc_i          (desc_i),
    .desc_valid_i    (desc_valid_i),
    .desc_ready_o    (desc_ready_o),
    .w_chan_slv_i    (w_chan_slv_i),
    .w_chan_valid_i  (w_chan_valid_i),
    .w_chan_ready_o  (w_chan_ready_o),
    .b_chan_slv_o    (b_chan_slv_o),
    .b_chan_valid_o  (b_chan_valid_o),
    .b_chan_ready_i  (b_chan_ready_i),
    .way_inp_o       (way_inp_o),
    .way_inp_valid_o (way_inp_valid_o),
    .way_inp_ready_i (way_inp_ready_i),
    .w_unlock_o      (w_unlock_o),
    .w_unlock_req_o  (w_unlock_req_o),
    .w_unlock_gnt_i  (w_unlock_gnt_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state: pending stimulus, the descriptor in flight, queued B responses.
  desc_t   dq[$];
  w_chan_t wq[$];
  b_chan_t bq[$];
  desc_t   cur;
  bit      busy = 0, d_hold = 0, w_hold = 0, b_block = 0, wr_toggle = 0;
  int      k = 0, wr_left = 0, rel_hold = 0;
  int unsigned p_desc = 100, p_w = 100, p_wr = 100, p_gnt = 100, p_b = 100;
  int      unl_cnt, b_cnt, way_cnt, hold_cnt, exp_unl, exp_b, exp_way;

  function automatic bit rnd(input int unsigned p);
    return $urandom_range(99) < p;
  endfunction

  task automatic clr_cnt();
    unl_cnt = 0; b_cnt = 0; way_cnt = 0; hold_cnt = 0;
    exp_unl = 0; exp_b = 0; exp_way = 0;
  endtask

  task automatic add_desc(input int id, input logic [31:0] addr, input int len, input int size,
                          input logic [1:0] burst, input logic [1:0] resp, input bit last,
                          input int way, input int idx, input int strb);
    desc_t   d;
    w_chan_t w;
    d.a_x_id = IdW'(id);           d.a_x_addr = addr;
    d.a_x_len = LenW'(len);        d.a_x_size = 3'(size);
    d.a_x_burst = burst;           d.x_resp = resp;
    d.x_last = last;               d.way_ind = WayIndW'(way);
    d.index_partition = IndexLength'(idx);
    dq.push_back(d);
    for (int i = 0; i <= len; i++) begin
      w.data = {$urandom, $urandom};
      w.strb = (strb < 0) ? StrbW'($urandom) : StrbW'(strb);
      w.last = last && (i == len);
      wq.push_back(w);
    end
    exp_unl++;
    exp_way += len + 1;
    if (last) exp_b++;
  endtask

  task automatic monitor();
    bit          busy0, wr_ph, un_ph;
    int          nb0;
    logic [31:0] a;
    b_chan_t     eb;
    w_chan_t     ew;
    busy0 = busy;
    wr_ph = busy && wr_left > 0;
    un_ph = busy && wr_left == 0;
    nb0   = bq.size();
    chk("desc_ready", 64'(desc_ready_o), 64'(!busy0));
    chk("way_valid", 64'(way_inp_valid_o), 64'(wr_ph && w_chan_valid_i));
    chk("w_ready", 64'(w_chan_ready_o), 64'(wr_ph && way_inp_ready_i));
    chk("unlock_req", 64'(w_unlock_req_o), 64'(un_ph));
    chk("b_valid", 64'(b_chan_valid_o), 64'(nb0 > 0));
    if (b_chan_valid_o && b_chan_ready_i && nb0 > 0) begin
      eb = bq.pop_front();
      chk("b_id", 64'(b_chan_slv_o.id), 64'(eb.id));
      chk("b_resp", 64'(b_chan_slv_o.resp), 64'(eb.resp));
      b_cnt++;
    end
    if (wr_ph && w_chan_valid_i && way_inp_ready_i) begin
      ew = wq.pop_front();
      if (cur.a_x_burst == BURST_FIXED) a = cur.a_x_addr;
      else a = ((cur.a_x_addr >> cur.a_x_size) + 32'(k)) << cur.a_x_size;
      chk("way_blk", 64'(way_inp_o.blk_offset), 64'((a >> 3) & 32'h7));
      chk("way_line", 64'(way_inp_o.line_addr), 64'(cur.index_partition));
      chk("way_ind", 64'(way_inp_o.way_ind), 64'(cur.way_ind));
      chk("way_we", 64'(way_inp_o.we), 64'd1);
      chk("way_unit", 64'(way_inp_o.cache_unit), 64'(WChanUnit));
      chk("way_data", way_inp_o.data, ew.data);
      chk("way_be", 64'(way_inp_o.be), 64'((cur.x_resp == RESP_OKAY) ? ew.strb : 8'h00));
      k++; wr_left--; way_cnt++;
      w_hold = 0;
    end else begin
      w_hold = w_chan_valid_i;
    end
    if (un_ph) begin
      chk("unlock_idx", 64'(w_unlock_o.index), 64'(cur.index_partition));
      chk("unlock_way", 64'(w_unlock_o.way_ind), 64'(cur.way_ind));
      if (w_unlock_gnt_i) begin
        if (cur.x_last && nb0 >= Depth) hold_cnt++;
        else begin
          unl_cnt++;
          if (cur.x_last) bq.push_back('{id: cur.a_x_id, resp: cur.x_resp});
          busy = 0;
        end
      end
    end
    if (!busy0 && desc_valid_i) begin
      cur = dq.pop_front();
      busy = 1; wr_left = int'(cur.a_x_len) + 1; k = 0; d_hold = 0;
    end else begin
      d_hold = desc_valid_i;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    desc_valid_i = dq.size() > 0 && (d_hold || rnd(p_desc));
    if (dq.size() > 0) desc_i = dq[0];
    w_chan_valid_i = wq.size() > 0 && (w_hold || rnd(p_w));
    if (wq.size() > 0) w_chan_slv_i = wq[0];
    way_inp_ready_i = wr_toggle ? !way_inp_ready_i : rnd(p_wr);
    w_unlock_gnt_i  = rnd(p_gnt);
    b_chan_ready_i  = b_block ? 1'b0 : rnd(p_b);
    @(negedge clk);
    monitor();
  endtask

  task automatic run_phase(input string name, input int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      if (b_block && rel_hold > 0 && hold_cnt >= rel_hold) b_block = 0;
      done = dq.size() == 0 && wq.size() == 0 && !busy && bq.size() == 0;
    end
    chk({name, ":done"}, 64'(done), 64'd1);
    chk({name, ":unlocks"}, 64'(unl_cnt), 64'(exp_unl));
    chk({name, ":b_count"}, 64'(b_cnt), 64'(exp_b));
    chk({name, ":beats"}, 64'(way_cnt), 64'(exp_way));
  endtask

  task automatic reset_checks(input string name);
    chk({name, ":desc_ready"}, 64'(desc_ready_o), 64'd1);
    chk({name, ":way_valid"}, 64'(way_inp_valid_o), 64'd0);
    chk({name, ":w_ready"}, 64'(w_chan_ready_o), 64'd0);
    chk({name, ":unlock_req"}, 64'(w_unlock_req_o), 64'd0);
    chk({name, ":b_valid"}, 64'(b_chan_valid_o), 64'd0);
  endtask

  initial begin
    // Reset with busy-looking inputs: the unit must still look idle.
    desc_valid_i = 1; w_chan_valid_i = 1; way_inp_ready_i = 1;
    w_unlock_gnt_i = 1; b_chan_ready_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    desc_valid_i = 0; w_chan_valid_i = 0; way_inp_ready_i = 0;
    w_unlock_gnt_i = 0; b_chan_ready_i = 0;
    @(posedge clk); #1 rst_ni = 1;

    clr_cnt();
    add_desc(5, 32'h40, 0, 3, BURST_INCR, RESP_OKAY, 1, 2, 9, 8'hF0);
    run_phase("single", 200);

    clr_cnt();
    add_desc(1, 32'h100, 3, 3, BURST_INCR, RESP_OKAY, 1, 1, 3, -1);
    run_phase("incr", 200);

    clr_cnt();
    add_desc(2, 32'h218, 2, 3, BURST_FIXED, RESP_OKAY, 1, 3, 7, -1);
    run_phase("fixed", 200);

    clr_cnt();
    add_desc(3, 32'h80, 2, 3, BURST_INCR, RESP_SLVERR, 1, 0, 12, 8'hFF);
    run_phase("slverr", 200);

    clr_cnt();
    wr_toggle = 1; b_block = 1; rel_hold = 3;
    for (int i = 0; i < 3; i++)
      add_desc(8 + i, 32'h1000 + 32'(i * 64), 1, 3, BURST_INCR, RESP_OKAY, 1, i, 20 + i, -1);
    run_phase("bp", 400);
    chk("bp:third_unlock_held", 64'(hold_cnt >= 3), 64'd1);
    wr_toggle = 0; b_block = 0; rel_hold = 0;

    clr_cnt();
    add_desc(6, 32'h300, 1, 3, BURST_INCR, RESP_OKAY, 0, 1, 30, -1);
    add_desc(6, 32'h340, 2, 3, BURST_INCR, RESP_OKAY, 1, 2, 31, -1);
    run_phase("split", 300);

    clr_cnt();
    for (int r = 0; r < 4; r++) begin
      p_desc = $urandom_range(100, 20); p_w = $urandom_range(100, 20);
      p_wr = $urandom_range(100, 20);   p_gnt = $urandom_range(100, 20);
      p_b = $urandom_range(100, 10);
      for (int i = 0; i < 12; i++)
        add_desc(int'($urandom_range(15)), $urandom, int'($urandom_range(7)),
                 int'($urandom_range(3)), 2'($urandom_range(2)),
                 rnd(75) ? RESP_OKAY : 2'($urandom_range(3)), rnd(60),
                 int'($urandom_range(3)), int'($urandom_range(63)), -1);
      run_phase("random", 5000);
      clr_cnt();
    end
    p_desc = 100; p_w = 100; p_wr = 100; p_gnt = 100; p_b = 100;

    // Reset in the middle of a burst returns the unit to idle.
    clr_cnt();
    add_desc(4, 32'h500, 5, 3, BURST_INCR, RESP_OKAY, 0, 1, 40, -1);
    for (int c = 0; c < 50 && way_cnt < 2; c++) step();
    chk("mid:beats_before_reset", 64'(way_cnt), 64'd2);
    @(posedge clk); #1;
    rst_ni = 0; desc_valid_i = 0; w_chan_valid_i = 1;
    @(posedge clk);
    @(negedge clk);
    reset_checks("mid_reset");
    dq.delete(); wq.delete(); bq.delete();
    busy = 0; d_hold = 0; w_hold = 0;
    w_chan_valid_i = 0;
    @(posedge clk); #1 rst_ni = 1;

    clr_cnt();
    add_desc(7, 32'h88, 0, 3, BURST_INCR, RESP_OKAY, 1, 3, 50, -1);
    run_phase("recover", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
